demux8_collector: RTL and testbench
===================================

Name: demux8_collector

Overview:
- 1-to-8 demultiplexing collector: the inverse of the team's 8:1 bit-select mux.
- Accepts one bit per handshake and steers it into a slot of an 8-bit assembly register. The slot comes from an external select or an internal auto-increment counter.
- When all slots are filled, the assembled word is presented on a valid/ready output port.
- Sits on the receive side of bit-serial links whose transmit side uses the 8:1 mux.

Parameters:
WIDTH, 8, number of slots / output word width; power of two, >= 2
SEL_W, $clog2(WIDTH), select width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_bit  input  1  serial data bit
in_valid  input  1  in_bit is valid this cycle
in_ready  output  1  block accepts in_bit this cycle
sel  input  SEL_W  target slot in explicit mode
sel_mode  input  1  0 = auto counter, 1 = explicit sel; latched only at frame start
clr  input  1  synchronous abort of the partial frame
out_data  output  WIDTH  assembled word
out_valid  output  1  out_data holds a complete word
out_ready  input  1  consumer accepts out_data
slot_strobe  output  WIDTH  registered one-hot pulse marking the slot written last cycle

Behaviour:
- Reset values (asynchronous, while rst = 1):
  - out_data = 0, out_valid = 0, slot_strobe = 0.
  - Assembly register = 0, write mask = 0, counter = 0, mode_q = 0, state = COLLECT.
  - in_ready = 1 once rst deasserts.
- Accept: accept = in_valid & in_ready. in_ready = (state == COLLECT).
- Mode latch:
  - mode_q <= sel_mode on any cycle where the frame is empty (mask == 0 and counter == 0).
  - The slot for an accept during an empty-frame cycle uses sel_mode directly.
  - Otherwise mode_q is held for the whole frame.
- Slot selection: auto mode uses slot = counter; explicit mode uses slot = sel.
- On accept:
  - asm[slot] <= in_bit and mask[slot] <= 1.
  - Auto mode only: counter increments, wrapping WIDTH-1 -> 0.
  - slot_strobe <= one-hot(slot) for exactly one cycle; it is 0 on any cycle following no accept.
- Duplicate explicit write to a slot already written: the bit is overwritten, the mask is unchanged, and the frame is not completed.
- Frame completion happens on the accept that makes the frame full:
  - auto mode: counter == WIDTH-1;
  - explicit mode: (mask | one-hot(sel)) == all ones.
- Completion handling:
  - Output free (out_valid = 0, or out_ready = 1 this cycle): next cycle out_data = completed word including the final bit, and out_valid = 1. Assembly, mask and counter clear. State stays COLLECT.
  - Output occupied (out_valid = 1 and out_ready = 0): the completed word stays in assembly and state -> STALL (in_ready = 0).
- STALL -> COLLECT on the first cycle with out_ready = 1. That cycle the assembly word transfers to out_data, out_valid stays 1, and assembly clears.
- Output handshake:
  - out_valid & out_ready with no new word transferring -> out_valid = 0 next cycle.
  - out_data is held stable while out_valid = 1 and out_ready = 0.
- Latency: the final bit accepted at cycle N is visible on out_data/out_valid at cycle N+1. Maximum sustained throughput is one bit per cycle with no bubbles.
- clr:
  - Clears assembly, mask and counter next cycle and returns STALL -> COLLECT.
  - Any accept in the same cycle is discarded.
  - The output register and out_valid are not affected.
  - clr has priority over completion.
- Reset mid-frame or mid-stall discards everything immediately, including a pending output word.

Decomposition:
- Shared package `demux_pkg`:
  - state enum {COLLECT, STALL};
  - MODE_AUTO = 1'b0 and MODE_EXPLICIT = 1'b1;
  - a onehot(slot) function, reused by the existing mux tests.
- One natural sub-module: `slot_decoder`, a combinational SEL_W -> WIDTH one-hot decoder used for both the write enable and slot_strobe. All other logic stays in the top module.

Test Plan:
- Auto mode, out_ready = 1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data = 8'h4D, out_valid for 1 cycle at N+1, slot_strobe walks 01 -> 02 -> ... -> 80.
- Explicit mode, sel = 7..0 descending with in_bit = 1 only at sel = 3 -> out_data = 8'h08. A repeated sel = 3 with bit 0 before the last slot is written -> bit 3 = 0, no early completion.
- Back-pressure: out_ready = 0, two auto frames 8'hA5 then 8'h3C -> first word held stable, STALL with in_ready = 0 after the second frame. Raising out_ready for one cycle -> out_data = 8'h3C, out_valid stays 1.
- Completion with out_valid = 1 and out_ready = 1 in the same cycle -> new word loads with no bubble, out_valid never drops.
- clr after 5 auto bits, then a full frame of 8'hFF -> out_data = 8'hFF (no stale bits), counter restarted at slot 0. sel_mode toggled mid-frame is ignored until the next frame.
- Assert rst asynchronously mid-frame and in STALL -> all outputs 0 immediately, in_ready = 1 after release, next frame assembles correctly.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and helpers for the bit demux collector
package demux_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_e;

  localparam logic MODE_AUTO     = 1'b0;
  localparam logic MODE_EXPLICIT = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = $clog2(DEF_WIDTH);

  function automatic logic [DEF_WIDTH-1:0] onehot(input logic [DEF_SEL_W-1:0] slot);
    onehot       = '0;
    onehot[slot] = 1'b1;
  endfunction

endpackage

// File: rtl/slot_decoder.sv
// rtl/slot_decoder.sv - select to one-hot slot decoder
module slot_decoder #(
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [WIDTH-1:0] o_onehot
);

  always_comb begin
    o_onehot        = '0;
    o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/demux8_collector.sv
// rtl/demux8_collector.sv - serial bit to parallel word collector
// Steers one bit per handshake into a slot chosen by counter or sel; emits full words on a valid/ready port.
module demux8_collector
  import demux_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_mode,
  input  logic             clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] slot_strobe
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] r_mask;
  logic [SEL_W-1:0] r_cnt;
  logic             r_mode_q;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_strobe;

  logic             w_empty;
  logic             w_mode;
  logic [SEL_W-1:0] w_slot;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_asm_new;
  logic             w_complete;
  logic             w_out_free;
  logic             w_wr;
  logic             w_load_out;
  logic             w_clr_frame;
  logic [WIDTH-1:0] w_load_word;

  // The first bit of a frame must follow the live sel_mode, not the stale latch.
  assign w_empty    = (r_mask == '0) && (r_cnt == '0);
  assign w_mode     = w_empty ? sel_mode : r_mode_q;
  assign w_slot     = (w_mode == MODE_AUTO) ? r_cnt : sel;
  assign w_asm_new  = in_bit ? (r_asm | w_dec) : (r_asm & ~w_dec);
  assign w_complete = (w_mode == MODE_EXPLICIT) ? ((r_mask | w_dec) == '1)
                                                : (r_cnt == SEL_W'(WIDTH - 1));
  assign w_out_free = !r_out_valid || out_ready;

  slot_decoder #(.WIDTH(WIDTH)) u_slot_decoder (
    .i_sel    (w_slot),
    .o_onehot (w_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_wr        = 1'b0;
    w_load_out  = 1'b0;
    w_clr_frame = 1'b0;
    w_load_word = w_asm_new;
    case (r_state)
      COLLECT: begin
        in_ready = 1'b1;
        if (clr) begin
          w_clr_frame = 1'b1;
        end else if (in_valid) begin
          w_wr = 1'b1;
          if (w_complete) begin
            if (w_out_free) begin
              w_load_out  = 1'b1;
              w_clr_frame = 1'b1;
            end else begin
              w_state_nxt = STALL;
            end
          end
        end
      end
      STALL: begin
        w_load_word = r_asm;
        if (clr) begin
          w_clr_frame = 1'b1;
          w_state_nxt = COLLECT;
        end else if (out_ready) begin
          w_load_out  = 1'b1;
          w_clr_frame = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm       <= '0;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_mode_q    <= MODE_AUTO;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_strobe    <= '0;
    end else begin
      r_strobe <= w_wr ? w_dec : '0;
      if (w_empty) begin
        r_mode_q <= sel_mode;
      end
      if (w_clr_frame) begin
        r_asm  <= '0;
        r_mask <= '0;
        r_cnt  <= '0;
      end else if (w_wr) begin
        r_asm  <= w_asm_new;
        r_mask <= r_mask | w_dec;
        if (w_mode == MODE_AUTO) begin
          r_cnt <= r_cnt + SEL_W'(1);
        end
      end
      if (w_load_out) begin
        r_out_data  <= w_load_word;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign slot_strobe = r_strobe;

endmodule

// File: tb/tb_demux8_collector.sv
// tb/tb_demux8_collector.sv - directed and random checks of demux8_collector against a frame model
module tb_demux8_collector;
  import demux_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] sel = 3'd0;
  logic       sel_mode = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] slot_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: frame as filled-slot set plus bit values; auto slot = bits collected so far.
  logic [7:0] m_frame = '0;
  bit   [7:0] m_have  = '0;
  int         m_nfill = 0;
  bit         m_mode  = 1'b0;
  bit         m_stall = 1'b0;
  logic [7:0] m_out   = '0;
  bit         m_outv  = 1'b0;
  logic [7:0] m_strobe = '0;

  demux8_collector #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .sel_mode    (sel_mode),
    .clr         (clr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .slot_strobe (slot_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_frame();
    m_frame = '0;
    m_have  = '0;
    m_nfill = 0;
  endtask

  task automatic model_reset();
    model_clear_frame();
    m_mode   = 1'b0;
    m_stall  = 1'b0;
    m_out    = '0;
    m_outv   = 1'b0;
    m_strobe = '0;
  endtask

  task automatic step(input bit b, input bit v, input int s, input bit m, input bit c, input bit ordy);
    bit acc;
    bit mode;
    bit loaded;
    int slot;
    in_bit    = b;
    in_valid  = v;
    sel       = 3'(s);
    sel_mode  = m;
    clr       = c;
    out_ready = ordy;
    @(posedge clk);
    acc  = v && !m_stall && !c;
    mode = (m_nfill == 0) ? m : m_mode;
    if (m_nfill == 0) m_mode = m;
    slot = (mode == MODE_AUTO) ? m_nfill : s;
    m_strobe = acc ? onehot(3'(slot)) : 8'h00;
    loaded = 1'b0;
    if (c) begin
      model_clear_frame();
      m_stall = 1'b0;
    end else if (m_stall) begin
      if (ordy) begin
        m_out = m_frame;
        loaded = 1'b1;
        model_clear_frame();
        m_stall = 1'b0;
      end
    end else if (acc) begin
      m_frame[slot] = b;
      if (!m_have[slot]) begin
        m_have[slot] = 1'b1;
        m_nfill++;
      end
      if (m_nfill == 8) begin
        if (!m_outv || ordy) begin
          m_out = m_frame;
          loaded = 1'b1;
          model_clear_frame();
        end else begin
          m_stall = 1'b1;
        end
      end
    end
    if (loaded) m_outv = 1'b1;
    else if (ordy) m_outv = 1'b0;
    #1;
    chk("out_valid", out_valid, m_outv);
    chk("out_data", out_data, m_out);
    chk("slot_strobe", slot_strobe, m_strobe);
    chk("in_ready", in_ready, !m_stall);
  endtask

  task automatic send_auto(input logic [7:0] w, input bit ordy);
    for (int i = 0; i < 8; i++) step(w[i], 1'b1, 0, 1'b0, 1'b0, ordy);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, ordy);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_strobe", slot_strobe, 8'h00);
    in_valid = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_strobe", slot_strobe, 8'h00);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);

    // Auto mode word, LSB first
    send_auto(8'h4D, 1'b1);
    chk("auto_word", out_data, 8'h4D);
    chk("auto_last_strobe", slot_strobe, 8'h80);
    idle(1'b1);
    chk("auto_valid_drop", out_valid, 1'b0);

    // Explicit descending sel, only slot 3 set
    for (int s = 7; s >= 0; s--) step(s == 3, 1'b1, s, 1'b1, 1'b0, 1'b1);
    chk("expl_word", out_data, 8'h08);
    idle(1'b1);
    // Duplicate write to slot 3 overwrites and does not complete early
    for (int s = 7; s >= 3; s--) step(1'b1, 1'b1, s, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1);
    chk("dup_no_complete", out_valid, 1'b0);
    for (int s = 2; s >= 0; s--) step(1'b0, 1'b1, s, 1'b1, 1'b0, 1'b1);
    chk("dup_word", out_data, 8'hF0);
    idle(1'b1);

    // Back-pressure: second frame stalls behind first
    send_auto(8'hA5, 1'b0);
    send_auto(8'h3C, 1'b0);
    chk("bp_hold", out_data, 8'hA5);
    chk("bp_stall_ready", in_ready, 1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("bp_release_word", out_data, 8'h3C);
    chk("bp_release_valid", out_valid, 1'b1);
    idle(1'b1);

    // Completion during a same-cycle handshake: no bubble
    send_auto(8'h5A, 1'b1);
    for (int i = 0; i < 7; i++) step(i[0] ? 1'b1 : 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    chk("nobubble_word", out_data, 8'hAA);
    chk("nobubble_valid", out_valid, 1'b1);
    idle(1'b1);

    // clr after 5 bits, accept in the clr cycle is discarded
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1);
    chk("clr_restart_slot0", slot_strobe, 8'h01);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 3, i[0], 1'b0, 1'b1);
    chk("clr_full_word", out_data, 8'hFF);
    idle(1'b1);

    // Async reset mid-frame
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    async_reset();
    // Async reset in STALL
    send_auto(8'h11, 1'b0);
    send_auto(8'h22, 1'b0);
    chk("pre_rst_stall", in_ready, 1'b0);
    async_reset();
    send_auto(8'h96, 1'b1);
    chk("post_rst_word", out_data, 8'h96);
    idle(1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom), ($urandom % 4) != 0, int'($urandom % 8), 1'($urandom),
           ($urandom % 40) == 0, ($urandom % 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
